// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Operand, command and result bundle between the execute-stage control and
//   the iterative multiply/divide unit.
//   master : drives start/op/a/b and the MTHI/MTLO writes (hi_we, lo_we, wdata),
//            observes busy/done/hi/lo.
//   slave  : the multiply/divide unit itself.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   One radix-2 step per cycle for WIDTH cycles, then one sign-fix cycle that
//   writes HI/LO. MTHI/MTLO writes are accepted only while idle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   mdu      slave side of mult_div_unit_if (start/op/a/b, hi_we/lo_we/wdata,
//            busy/done/hi/lo)
// op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  mult_div_unit_if.slave   mdu
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  // Multiply: {partial product high, multiplier shifting out low}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;     // multiplicand or divisor magnitude
  logic               is_div_reg;
  logic               neg_q_reg;    // product / quotient must be negated
  logic               neg_r_reg;    // remainder takes the dividend's sign
  logic               div0_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Magnitudes are kept unsigned, so |0x80000000| is simply 0x80000000.
  assign is_signed = ~mdu.op[0];
  assign a_mag     = (is_signed && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
  assign b_mag     = (is_signed && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring step: shift next dividend bit into the remainder, keep the
  // difference only when it did not borrow.
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

  // Sign fix. With a zero divisor the remainder equals |a|; re-applying the
  // dividend sign reproduces the raw launched a, so only LO needs overriding.
  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  assign fix_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div_reg ? (div0_reg ? '1 : quot_fix) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mdu.start) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mdu.start) begin
            // start has priority; simultaneous MTHI/MTLO writes are dropped
            cnt_reg    <= '0;
            acc_reg    <= {{WIDTH{1'b0}}, a_mag};
            opnd_reg   <= b_mag;
            is_div_reg <= mdu.op[1];
            neg_q_reg  <= is_signed & (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
            neg_r_reg  <= is_signed & mdu.a[WIDTH-1];
            div0_reg   <= (mdu.b == '0);
          end else begin
            if (mdu.hi_we) hi_reg <= mdu.wdata;
            if (mdu.lo_we) lo_reg <= mdu.wdata;
          end
        end
        CALC: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mdu.busy = (state_reg != IDLE);
  assign mdu.done = done_reg;
  assign mdu.hi   = hi_reg;
  assign mdu.lo   = lo_reg;

endmodule
